// File: rtl/data_sync_pkg.sv
// -----------------------------------------------------------------------------
// data_sync_pkg
// Shared definitions for the bus-synchronizer launcher (data_sync_tx) and the
// destination-side synchronizer.
//   - data_sync_state_e : launcher FSM states
//   - DEFAULT_*         : default word width / hold / gap lengths. The width
//                         must match the synchronizer's BUS_WIDTH.
//   - cnt_width()       : width of the hold/gap down-counter
// -----------------------------------------------------------------------------
package data_sync_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_HOLD  = 2'd2,
      ST_GAP   = 2'd3
   } data_sync_state_e;

   localparam int DEFAULT_BUS_WIDTH   = 8;
   localparam int DEFAULT_HOLD_CYCLES = 4;
   localparam int DEFAULT_GAP_CYCLES  = 4;

   // The counter only ever holds (cycles-1), so $clog2 of the larger length
   // is enough; a single-cycle window still needs one bit.
   function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
      int m;
      int w;
      m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/data_sync_tx_buf.sv
// -----------------------------------------------------------------------------
// data_sync_tx_buf
// Two-entry FIFO placed in front of the launcher FSM when DATA_SYNC_TX_BUF_EN
// is defined.
// Ports:
//   CLK      in  : clock, rising edge
//   RST      in  : asynchronous active-low reset (FIFO empties)
//   push     in  : write wr_data (ignored when full unless popping as well)
//   pop      in  : drop the head entry (ignored when empty)
//   wr_data  in  : word to store
//   rd_data  out : head entry, valid while !empty
//   full     out : two entries held
//   empty    out : no entries held
// Push and pop in the same cycle while full is legal: the head is read from
// the old storage while the freed slot takes the new word, so order holds.
// -----------------------------------------------------------------------------
module data_sync_tx_buf #(
   parameter int W = 8
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   logic [W-1:0] mem [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic [1:0]   count;
   logic         do_push;
   logic         do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         mem[0] <= '0;
         mem[1] <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/data_sync_tx.sv
// -----------------------------------------------------------------------------
// data_sync_tx
// Source-side launcher for the multi-flop bus synchronizer. Each accepted word
// is put on unsync_bus one cycle before bus_enable rises, bus_enable is held
// high for HOLD_CYCLES and then low for at least GAP_CYCLES, so the
// destination sees one enable pulse and one clean capture per word.
//
// Handshake: a word transfers on a rising CLK where in_valid && in_ready.
// in_ready never depends combinationally on in_valid; a refused word must be
// held by the upstream, and in_data is only sampled on the accept edge.
//
// Ports:
//   CLK        in  : source clock, rising edge
//   RST        in  : asynchronous active-low reset
//   in_data    in  : word to transfer (BUS_WIDTH)
//   in_valid   in  : in_data valid
//   in_ready   out : a word can be accepted this cycle
//   unsync_bus out : registered data to the synchronizer
//   bus_enable out : registered enable level to the synchronizer
//   busy       out : FSM not idle, or a word is buffered
//   dbg_state  out : current FSM state, for observation only
//
// Build option DATA_SYNC_TX_BUF_EN: adds a 2-entry input FIFO; words are then
// accepted in any state and back-to-back words skip the IDLE cycle.
// Without it, in_ready is high only in IDLE.
//
// HOLD_CYCLES and GAP_CYCLES, seen in destination time, must each exceed the
// synchronizer depth + 1; nothing here checks that.
// -----------------------------------------------------------------------------
module data_sync_tx
   import data_sync_pkg::*;
#(
   parameter int BUS_WIDTH   = DEFAULT_BUS_WIDTH,
   parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
   parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BUS_WIDTH-1:0] unsync_bus,
   output logic                 bus_enable,
   output logic                 busy,
   output data_sync_state_e     dbg_state
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   data_sync_state_e       state;
   logic [CNT_W-1:0]       cnt;
   logic                   launch_ok;    // a word is available to launch
   logic [BUS_WIDTH-1:0]   launch_data;  // the word that would be launched
   logic                   launch;       // FSM takes a word this cycle

`ifdef DATA_SYNC_TX_BUF_EN
   localparam bit CHAIN_EN = 1'b1;

   logic                 buf_full;
   logic                 buf_empty;
   logic [BUS_WIDTH-1:0] buf_data;

   data_sync_tx_buf #(
      .W (BUS_WIDTH)
   ) u_buf (
      .CLK     (CLK),
      .RST     (RST),
      .push    (in_valid && !buf_full),
      .pop     (launch),
      .wr_data (in_data),
      .rd_data (buf_data),
      .full    (buf_full),
      .empty   (buf_empty)
   );

   // full/empty come from the FIFO's count register, so these stay free of
   // any in_valid path.
   assign in_ready    = !buf_full;
   assign launch_ok   = !buf_empty;
   assign launch_data = buf_data;
   assign busy        = (state != ST_IDLE) || !buf_empty;
`else
   localparam bit CHAIN_EN = 1'b0;

   assign in_ready    = (state == ST_IDLE);
   assign launch_ok   = in_valid;
   assign launch_data = in_data;
   assign busy        = (state != ST_IDLE);
`endif

   // Launch from IDLE, or (buffered build only) straight out of the last GAP
   // cycle so a queued word does not pay for an IDLE cycle.
   assign launch = launch_ok &&
                   ((state == ST_IDLE) ||
                    (CHAIN_EN && (state == ST_GAP) && (cnt == '0)));

   assign dbg_state = state;

   // unsync_bus only loads on the edge that enters SETUP, when bus_enable is
   // already low; it is therefore stable for the SETUP cycle and the whole
   // HOLD window.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         unsync_bus <= '0;
         bus_enable <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  unsync_bus <= launch_data;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               bus_enable <= 1'b1;
               cnt        <= HOLD_LOAD;
               state      <= ST_HOLD;
            end
            ST_HOLD: begin
               if (cnt == '0) begin
                  bus_enable <= 1'b0;
                  cnt        <= GAP_LOAD;
                  state      <= ST_GAP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt == '0) begin
                  if (launch) begin
                     unsync_bus <= launch_data;
                     state      <= ST_SETUP;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               bus_enable <= 1'b0;
               state      <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_sync_tx.sv
// -----------------------------------------------------------------------------
// tb_data_sync_tx
// Bench for data_sync_tx. Edges are counted the way a sampling flop sees
// them: the value checked "at edge k" is the one present just before rising
// edge k (sampled on the preceding falling edge).
//
// Timing model: every accepted word gets a launch edge L (the edge that moves
// the FSM into SETUP). unsync_bus carries the word at edge L+1, bus_enable is
// high at edges L+2..L+1+HOLD, and the launcher is occupied until edge
// L+1+HOLD+GAP. Unbuffered, L is the accept edge; buffered, L is the later of
// (accept+1) and (previous L + 1+HOLD+GAP).
// -----------------------------------------------------------------------------
module tb_data_sync_tx;
   import data_sync_pkg::*;

   localparam int BW = 8;
   localparam int H  = 4;
   localparam int G  = 4;
`ifdef DATA_SYNC_TX_BUF_EN
   localparam bit BUF = 1'b1;
`else
   localparam bit BUF = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk_tb = 1'b0;
   logic rst_n  = 1'b0;
   always #5 clk_tb = ~clk_tb;

   int cyc = 0;
   always @(posedge clk_tb) cyc <= cyc + 1;

   logic [BW-1:0]    in_data  = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [BW-1:0]    unsync_bus;
   logic             bus_enable;
   logic             busy;
   data_sync_state_e dbg_state;

   data_sync_tx #(
      .BUS_WIDTH   (BW),
      .HOLD_CYCLES (H),
      .GAP_CYCLES  (G)
   ) dut (
      .CLK        (clk_tb),
      .RST        (rst_n),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .unsync_bus (unsync_bus),
      .bus_enable (bus_enable),
      .busy       (busy),
      .dbg_state  (dbg_state)
   );

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", name, cyc + 1, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [BW-1:0] exp_q[$];     // words in launch order
   int            exp_t_q[$];   // edge at which each word's enable is first seen high
   int            sched_q[$];   // launch edges still affecting outputs
   int            last_launch = -1000;

   int  m_e, m_l, m_occ;
   bit  m_active, m_en;

   always @(negedge clk_tb) begin
      if (rst_n) begin
         m_e = cyc + 1;
         while (sched_q.size() > 0 && sched_q[0] + 1 + H + G <= m_e - 1)
            void'(sched_q.pop_front());
         m_occ = 0; m_active = 1'b0; m_en = 1'b0;
         foreach (sched_q[i]) begin
            m_l = sched_q[i];
            if (m_l > m_e - 1) m_occ++;
            if (m_l <= m_e - 1 && m_e - 1 < m_l + 1 + H + G) m_active = 1'b1;
            if (m_l + 2 <= m_e && m_e <= m_l + 1 + H) m_en = 1'b1;
         end
         chk("in_ready",   32'(in_ready),   BUF ? 32'(m_occ < 2) : 32'(!m_active));
         chk("busy",       32'(busy),       32'((m_occ > 0) || m_active));
         chk("bus_enable", 32'(bus_enable), 32'(m_en));
         if (in_valid && in_ready) begin
            if (BUF) m_l = (m_e + 1 > last_launch + 1 + H + G) ? m_e + 1 : last_launch + 1 + H + G;
            else     m_l = m_e;
            last_launch = m_l;
            sched_q.push_back(m_l);
            exp_q.push_back(in_data);
            exp_t_q.push_back(m_l + 2);
         end
      end
   end

   // ---------------- scoreboard monitor ----------------
   logic          prev_en  = 1'b0;
   logic [BW-1:0] prev_bus = '0;
   logic [BW-1:0] sb_d;
   int            sb_t;

   always @(negedge clk_tb) begin
      if (!rst_n) begin
         prev_en  = 1'b0;
         prev_bus = '0;
      end else begin
         if (bus_enable && !prev_en) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_launch", 32'(unsync_bus), 32'hFFFF_FFFF);
            end else begin
               sb_d = exp_q.pop_front();
               sb_t = exp_t_q.pop_front();
               chk("launch_data", 32'(unsync_bus), 32'(sb_d));
               chk("launch_edge", 32'(cyc + 1), 32'(sb_t));
            end
         end
         // Covers both the cycle before the rise and every high cycle.
         if (bus_enable) chk("bus_stable", 32'(unsync_bus), 32'(prev_bus));
         prev_en  = bus_enable;
         prev_bus = unsync_bus;
      end
   end

   // ---------------- driver tasks ----------------
   // Entered at posedge+1; returns at posedge+1 after the accept edge with
   // in_valid still high so consecutive calls are back-to-back.
   task automatic send(input logic [BW-1:0] d);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk_tb);
         if (in_ready) done = 1'b1;
         @(posedge clk_tb);
         #1;
      end
      if (!done) begin
         chk("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         in_data = BW'($urandom);   // must never be captured
         @(posedge clk_tb);
         #1;
      end
   endtask

   task automatic check_reset_values();
      chk("rst_unsync_bus", 32'(unsync_bus), 32'd0);
      chk("rst_bus_enable", 32'(bus_enable), 32'd0);
      chk("rst_in_ready",   32'(in_ready),   32'd1);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_state",      32'(dbg_state),  32'(ST_IDLE));
   endtask

   // Asserted mid-cycle, away from both edges.
   task automatic pulse_reset();
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_reset_values();
      exp_q.delete();
      exp_t_q.delete();
      sched_q.delete();
      last_launch = -1000;
      repeat (3) @(posedge clk_tb);
      #2;
      rst_n = 1'b1;
      @(negedge clk_tb);
      chk("in_ready_after_release", 32'(in_ready), 32'd1);
      @(posedge clk_tb);
      #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int waited;
      repeat (2) @(posedge clk_tb);
      #1;
      check_reset_values();
      #1;
      rst_n = 1'b1;
      @(negedge clk_tb);
      chk("in_ready_after_release", 32'(in_ready), 32'd1);
      @(posedge clk_tb);
      #1;

      // single word
      send(8'h08);
      idle(15);

      // held valid: second word must wait for the first window to finish
      send(8'hA5);
      send(8'h3C);
      idle(15);

      // burst of three
      send(8'h01);
      send(8'h80);
      send(8'hFF);
      idle(3);

      // random words and gaps
      for (int i = 0; i < 24; i++) begin
         send(BW'($urandom));
         idle($urandom_range(0, 12));
      end
      idle(40);
      chk("drain_empty", 32'(exp_q.size()), 32'd0);

      // reset while mid-stream (in HOLD of 8'h55)
      send(8'h55);
      in_valid = 1'b0;
      waited = 0;
      while (!bus_enable && waited < 20) begin
         @(posedge clk_tb);
         #1;
         waited++;
      end
      chk("hold_reached", 32'(bus_enable), 32'd1);
      @(posedge clk_tb);
      pulse_reset();

      // normal transfer after the aborted window
      send(8'hAA);
      idle(40);

      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("final_busy",        32'(busy),         32'd0);
      chk("final_enable",      32'(bus_enable),   32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
